// File: rtl/axi_read_xbar.sv
`default_nettype none
// ============================================================================
// Module      : axi_read_xbar
// Description : NM-master / NS-slave AXI read crossbar with round-robin
//               arbitration per slave and an internal decode-error target.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_read_xbar #(
    parameter int NM        = 2,
    parameter int NS        = 2,
    parameter int IDM_BITS  = 4,
    parameter int MI_BITS   = (NM > 1) ? $clog2(NM) : 1,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4,
    parameter logic [NS*ADDR_BITS-1:0] SLV_BASE = {NS{32'h0}},
    parameter logic [NS*ADDR_BITS-1:0] SLV_MASK = {NS{32'hFFFF_0000}},
    localparam int IDS_BITS = IDM_BITS + MI_BITS
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [NM*IDM_BITS-1:0]    ARID_M,
    input  logic [NM*ADDR_BITS-1:0]   ARADDR_M,
    input  logic [NM*LEN_BITS-1:0]    ARLEN_M,
    input  logic [NM*3-1:0]           ARSIZE_M,
    input  logic [NM*2-1:0]           ARBURST_M,
    input  logic [NM-1:0]             ARVALID_M,
    output logic [NM-1:0]             ARREADY_M,
    output logic [NM*IDM_BITS-1:0]    RID_M,
    output logic [NM*DATA_BITS-1:0]   RDATA_M,
    output logic [NM*2-1:0]           RRESP_M,
    output logic [NM-1:0]             RLAST_M,
    output logic [NM-1:0]             RVALID_M,
    input  logic [NM-1:0]             RREADY_M,
    output logic [NS*IDS_BITS-1:0]    ARID_S,
    output logic [NS*ADDR_BITS-1:0]   ARADDR_S,
    output logic [NS*LEN_BITS-1:0]    ARLEN_S,
    output logic [NS*3-1:0]           ARSIZE_S,
    output logic [NS*2-1:0]           ARBURST_S,
    output logic [NS-1:0]             ARVALID_S,
    input  logic [NS-1:0]             ARREADY_S,
    input  logic [NS*IDS_BITS-1:0]    RID_S,
    input  logic [NS*DATA_BITS-1:0]   RDATA_S,
    input  logic [NS*2-1:0]           RRESP_S,
    input  logic [NS-1:0]             RLAST_S,
    input  logic [NS-1:0]             RVALID_S,
    output logic [NS-1:0]             RREADY_S
);

    localparam int NT      = NS + 1;
    localparam int TI_BITS = (NS > 0) ? $clog2(NS + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t               state_q  [NT];
    state_t               state_d  [NT];
    logic [MI_BITS-1:0]   grant_q  [NT];
    logic [MI_BITS-1:0]   grant_d  [NT];
    logic [MI_BITS-1:0]   rr_ptr_q [NT];
    logic [MI_BITS-1:0]   rr_ptr_d [NT];
    logic [NM-1:0]        busy_q;
    logic [NM-1:0]        busy_d;
    logic [LEN_BITS-1:0]  e_cnt_q;
    logic [LEN_BITS-1:0]  e_cnt_d;
    logic [IDM_BITS-1:0]  e_id_q;
    logic [IDM_BITS-1:0]  e_id_d;

    logic [TI_BITS-1:0]   w_tgt  [NM];
    logic [NT-1:0]        w_any;
    logic [MI_BITS-1:0]   w_pick [NT];
    logic [NT-1:0]        w_tgt_arready;
    logic [NT-1:0]        w_tgt_rvalid;
    logic [NT-1:0]        w_tgt_rlast;
    logic                 w_unused_rid;

    function automatic int wrap_idx(input logic [MI_BITS-1:0] ptr, input int k);
        return (int'(ptr) + k) % NM;
    endfunction

    // Address decode: lowest-index hit wins, no hit selects the error target.
    always_comb begin
        for (int m = 0; m < NM; m++) begin
            w_tgt[m] = TI_BITS'(NS);
            for (int j = NS - 1; j >= 0; j--) begin
                if ((ARADDR_M[m*ADDR_BITS +: ADDR_BITS] & SLV_MASK[j*ADDR_BITS +: ADDR_BITS])
                        == SLV_BASE[j*ADDR_BITS +: ADDR_BITS]) begin
                    w_tgt[m] = TI_BITS'(j);
                end
            end
        end
    end

    always_comb begin
        for (int t = 0; t < NT; t++) begin
            w_any[t]  = 1'b0;
            w_pick[t] = '0;
            for (int k = 0; k < NM; k++) begin
                if (!w_any[t] && ARVALID_M[wrap_idx(rr_ptr_q[t], k)]
                        && !busy_q[wrap_idx(rr_ptr_q[t], k)]
                        && (w_tgt[wrap_idx(rr_ptr_q[t], k)] == TI_BITS'(t))) begin
                    w_any[t]  = 1'b1;
                    w_pick[t] = MI_BITS'(wrap_idx(rr_ptr_q[t], k));
                end
            end
        end
    end

    assign w_tgt_arready = {1'b1, ARREADY_S};
    assign w_tgt_rvalid  = {1'b1, RVALID_S};
    assign w_tgt_rlast   = {(e_cnt_q == '0), RLAST_S};

    // Master index bits of RID_S are implied by the grant and not forwarded.
    always_comb begin
        w_unused_rid = 1'b0;
        for (int j = 0; j < NS; j++) begin
            w_unused_rid = w_unused_rid ^ (^RID_S[j*IDS_BITS+IDM_BITS +: MI_BITS]);
        end
    end

    always_comb begin
        ARREADY_M = '0;
        RID_M     = '0;
        RDATA_M   = '0;
        RRESP_M   = '0;
        RLAST_M   = '0;
        RVALID_M  = '0;
        ARID_S    = '0;
        ARADDR_S  = '0;
        ARLEN_S   = '0;
        ARSIZE_S  = '0;
        ARBURST_S = '0;
        ARVALID_S = '0;
        RREADY_S  = '0;
        for (int j = 0; j < NS; j++) begin
            if (state_q[j] == ST_ADDR) begin
                ARVALID_S[j]                         = ARVALID_M[grant_q[j]];
                ARID_S[j*IDS_BITS +: IDS_BITS]       = {grant_q[j], ARID_M[grant_q[j]*IDM_BITS +: IDM_BITS]};
                ARADDR_S[j*ADDR_BITS +: ADDR_BITS]   = ARADDR_M[grant_q[j]*ADDR_BITS +: ADDR_BITS];
                ARLEN_S[j*LEN_BITS +: LEN_BITS]      = ARLEN_M[grant_q[j]*LEN_BITS +: LEN_BITS];
                ARSIZE_S[j*3 +: 3]                   = ARSIZE_M[grant_q[j]*3 +: 3];
                ARBURST_S[j*2 +: 2]                  = ARBURST_M[grant_q[j]*2 +: 2];
                ARREADY_M[grant_q[j]]                = ARREADY_S[j];
            end else if (state_q[j] == ST_DATA) begin
                RVALID_M[grant_q[j]]                 = RVALID_S[j];
                RDATA_M[grant_q[j]*DATA_BITS +: DATA_BITS] = RDATA_S[j*DATA_BITS +: DATA_BITS];
                RRESP_M[grant_q[j]*2 +: 2]           = RRESP_S[j*2 +: 2];
                RLAST_M[grant_q[j]]                  = RLAST_S[j];
                RID_M[grant_q[j]*IDM_BITS +: IDM_BITS] = RID_S[j*IDS_BITS +: IDM_BITS];
                RREADY_S[j]                          = RREADY_M[grant_q[j]];
            end
        end
        // Error target accepts immediately and answers with DECERR beats.
        if (state_q[NS] == ST_ADDR) begin
            ARREADY_M[grant_q[NS]] = 1'b1;
        end else if (state_q[NS] == ST_DATA) begin
            RVALID_M[grant_q[NS]]                   = 1'b1;
            RRESP_M[grant_q[NS]*2 +: 2]             = 2'b11;
            RLAST_M[grant_q[NS]]                    = (e_cnt_q == '0);
            RID_M[grant_q[NS]*IDM_BITS +: IDM_BITS] = e_id_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        busy_d   = busy_q;
        e_cnt_d  = e_cnt_q;
        e_id_d   = e_id_q;
        for (int m = 0; m < NM; m++) begin
            if (ARVALID_M[m] && ARREADY_M[m]) begin
                busy_d[m] = 1'b1;
            end
            if (RVALID_M[m] && RREADY_M[m] && RLAST_M[m]) begin
                busy_d[m] = 1'b0;
            end
        end
        for (int t = 0; t < NT; t++) begin
            case (state_q[t])
                ST_IDLE: begin
                    if (w_any[t]) begin
                        grant_d[t] = w_pick[t];
                        state_d[t] = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (ARVALID_M[grant_q[t]] && w_tgt_arready[t]) begin
                        state_d[t] = ST_DATA;
                        if (t == NS) begin
                            e_cnt_d = ARLEN_M[grant_q[t]*LEN_BITS +: LEN_BITS];
                            e_id_d  = ARID_M[grant_q[t]*IDM_BITS +: IDM_BITS];
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tgt_rvalid[t] && RREADY_M[grant_q[t]]) begin
                        if (w_tgt_rlast[t]) begin
                            state_d[t]  = ST_IDLE;
                            rr_ptr_d[t] = (grant_q[t] == MI_BITS'(NM - 1)) ? '0 : grant_q[t] + 1'b1;
                        end else if (t == NS) begin
                            e_cnt_d = e_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d[t] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int t = 0; t < NT; t++) begin
                state_q[t]  <= ST_IDLE;
                grant_q[t]  <= '0;
                rr_ptr_q[t] <= '0;
            end
            busy_q  <= '0;
            e_cnt_q <= '0;
            e_id_q  <= '0;
        end else begin
            for (int t = 0; t < NT; t++) begin
                state_q[t]  <= state_d[t];
                grant_q[t]  <= grant_d[t];
                rr_ptr_q[t] <= rr_ptr_d[t];
            end
            busy_q  <= busy_d;
            e_cnt_q <= e_cnt_d;
            e_id_q  <= e_id_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_read_xbar.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_read_xbar
// Description : Directed self-checking bench for axi_read_xbar (2x2 map).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_read_xbar;

    logic        aclk;
    logic        areset;
    logic [7:0]  arid_m;
    logic [63:0] araddr_m;
    logic [7:0]  arlen_m;
    logic [5:0]  arsize_m;
    logic [3:0]  arburst_m;
    logic [1:0]  arvalid_m;
    logic [1:0]  arready_m;
    logic [7:0]  rid_m;
    logic [63:0] rdata_m;
    logic [3:0]  rresp_m;
    logic [1:0]  rlast_m;
    logic [1:0]  rvalid_m;
    logic [1:0]  rready_m;
    logic [9:0]  arid_s;
    logic [63:0] araddr_s;
    logic [7:0]  arlen_s;
    logic [5:0]  arsize_s;
    logic [3:0]  arburst_s;
    logic [1:0]  arvalid_s;
    logic [1:0]  arready_s;
    logic [9:0]  rid_s;
    logic [63:0] rdata_s;
    logic [3:0]  rresp_s;
    logic [1:0]  rlast_s;
    logic [1:0]  rvalid_s;
    logic [1:0]  rready_s;

    int checks;
    int errors;

    axi_read_xbar #(
        .NM       (2),
        .NS       (2),
        .SLV_BASE ({32'h0001_0000, 32'h0000_0000})
    ) dut (
        .ACLK      (aclk),
        .ARESET    (areset),
        .ARID_M    (arid_m),
        .ARADDR_M  (araddr_m),
        .ARLEN_M   (arlen_m),
        .ARSIZE_M  (arsize_m),
        .ARBURST_M (arburst_m),
        .ARVALID_M (arvalid_m),
        .ARREADY_M (arready_m),
        .RID_M     (rid_m),
        .RDATA_M   (rdata_m),
        .RRESP_M   (rresp_m),
        .RLAST_M   (rlast_m),
        .RVALID_M  (rvalid_m),
        .RREADY_M  (rready_m),
        .ARID_S    (arid_s),
        .ARADDR_S  (araddr_s),
        .ARLEN_S   (arlen_s),
        .ARSIZE_S  (arsize_s),
        .ARBURST_S (arburst_s),
        .ARVALID_S (arvalid_s),
        .ARREADY_S (arready_s),
        .RID_S     (rid_s),
        .RDATA_S   (rdata_s),
        .RRESP_S   (rresp_s),
        .RLAST_S   (rlast_s),
        .RVALID_S  (rvalid_s),
        .RREADY_S  (rready_s)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs;
        arid_m = '0; araddr_m = '0; arlen_m = '0; arsize_m = '0; arburst_m = '0;
        arvalid_m = '0; rready_m = '0; arready_s = '0; rid_s = '0; rdata_s = '0;
        rresp_s = '0; rlast_s = '0; rvalid_s = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        areset = 1'b1;
        rvalid_s = 2'b11; rdata_s = 64'hDEAD_BEEF_CAFE_F00D; rlast_s = 2'b11;
        arvalid_m = 2'b11; rready_m = 2'b11; arready_s = 2'b11;
        tick();
        #1;
        checks++; if (rvalid_m !== 2'b00) begin errors++; $display("FAIL reset_rvalid_m: got %b exp 00", rvalid_m); end
        checks++; if (rdata_m !== 64'h0) begin errors++; $display("FAIL reset_rdata_m: got %h exp 0", rdata_m); end
        checks++; if (arvalid_s !== 2'b00) begin errors++; $display("FAIL reset_arvalid_s: got %b exp 00", arvalid_s); end
        checks++; if (arready_m !== 2'b00) begin errors++; $display("FAIL reset_arready_m: got %b exp 00", arready_m); end
        checks++; if (rready_s !== 2'b00) begin errors++; $display("FAIL reset_rready_s: got %b exp 00", rready_s); end
        checks++; if (araddr_s !== 64'h0 || arid_s !== 10'h0) begin errors++; $display("FAIL reset_payload: araddr_s %h arid_s %h exp 0", araddr_s, arid_s); end
        areset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single_read;
        do_reset();
        arvalid_m = 2'b01; araddr_m[31:0] = 32'h0000_0010; arid_m[3:0] = 4'h5;
        arlen_m[3:0] = 4'd3; arsize_m[2:0] = 3'd2; arburst_m[1:0] = 2'd1; arready_s = 2'b11;
        #1;
        checks++; if (arvalid_s !== 2'b00) begin errors++; $display("FAIL single_bubble: arvalid_s %b exp 00", arvalid_s); end
        tick();
        checks++; if (arvalid_s !== 2'b01) begin errors++; $display("FAIL single_arvalid: got %b exp 01", arvalid_s); end
        checks++; if (arid_s[4:0] !== 5'h05) begin errors++; $display("FAIL single_arid: got %h exp 05", arid_s[4:0]); end
        checks++; if (araddr_s[31:0] !== 32'h10 || arlen_s[3:0] !== 4'd3 || arsize_s[2:0] !== 3'd2 || arburst_s[1:0] !== 2'd1)
            begin errors++; $display("FAIL single_payload: addr %h len %h size %h burst %h exp 10 3 2 1", araddr_s[31:0], arlen_s[3:0], arsize_s[2:0], arburst_s[1:0]); end
        checks++; if (arready_m !== 2'b01) begin errors++; $display("FAIL single_arready: got %b exp 01", arready_m); end
        tick();
        arvalid_m = 2'b00;
        for (int i = 0; i < 4; i++) begin
            rvalid_s = 2'b01; rdata_s[31:0] = 32'hA000_0000 + i; rid_s[4:0] = 5'h05;
            rlast_s[0] = (i == 3); rready_m = 2'b01;
            #1;
            checks++; if (rvalid_m !== 2'b01) begin errors++; $display("FAIL single_rvalid beat %0d: got %b exp 01", i, rvalid_m); end
            checks++; if (rdata_m !== {32'h0, 32'hA000_0000 + i}) begin errors++; $display("FAIL single_rdata beat %0d: got %h exp %h", i, rdata_m, 32'hA000_0000 + i); end
            checks++; if (rlast_m !== ((i == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL single_rlast beat %0d: got %b", i, rlast_m); end
            checks++; if (rid_m !== 8'h05 || rready_s !== 2'b01) begin errors++; $display("FAIL single_rid_rready beat %0d: rid %h rready_s %b exp 05 01", i, rid_m, rready_s); end
            tick();
        end
        rvalid_s = 2'b00; rlast_s = 2'b00;
        #1;
        checks++; if (rvalid_m !== 2'b00 || arvalid_s !== 2'b00) begin errors++; $display("FAIL single_done: rvalid_m %b arvalid_s %b exp 00 00", rvalid_m, arvalid_s); end
    endtask

    task automatic test_contention;
        do_reset();
        arvalid_m = 2'b11; araddr_m = {32'h0001_0000, 32'h0001_0004};
        arid_m = {4'h2, 4'h1}; arlen_m = 8'h00; arready_s = 2'b11; rready_m = 2'b11;
        tick();
        checks++; if (arvalid_s !== 2'b10 || arid_s[9:5] !== 5'h01) begin errors++; $display("FAIL cont_first_grant: arvalid_s %b arid %h exp 10 01", arvalid_s, arid_s[9:5]); end
        checks++; if (arready_m !== 2'b01 || araddr_s[63:32] !== 32'h0001_0004) begin errors++; $display("FAIL cont_first_ready: arready_m %b addr %h exp 01 00010004", arready_m, araddr_s[63:32]); end
        tick();
        arvalid_m = 2'b10;
        rvalid_s = 2'b10; rlast_s = 2'b10; rid_s[9:5] = 5'h01; rdata_s[63:32] = 32'h1111_1111;
        #1;
        checks++; if (rvalid_m !== 2'b01 || rdata_m[31:0] !== 32'h1111_1111 || arready_m !== 2'b00)
            begin errors++; $display("FAIL cont_m0_data: rvalid %b data %h arready %b exp 01 11111111 00", rvalid_m, rdata_m[31:0], arready_m); end
        tick();
        rvalid_s = 2'b00; rlast_s = 2'b00;
        #1;
        checks++; if (arvalid_s !== 2'b00) begin errors++; $display("FAIL cont_idle_bubble: got %b exp 00", arvalid_s); end
        tick();
        checks++; if (arvalid_s !== 2'b10 || arid_s[9:5] !== 5'h12 || arready_m !== 2'b10)
            begin errors++; $display("FAIL cont_second_grant: arvalid %b arid %h arready %b exp 10 12 10", arvalid_s, arid_s[9:5], arready_m); end
        tick();
        arvalid_m = 2'b00;
        rvalid_s = 2'b10; rlast_s = 2'b10; rid_s[9:5] = 5'h12; rdata_s[63:32] = 32'h2222_2222;
        #1;
        checks++; if (rvalid_m !== 2'b10 || rid_m[7:4] !== 4'h2 || rdata_m[63:32] !== 32'h2222_2222)
            begin errors++; $display("FAIL cont_m1_data: rvalid %b rid %h data %h exp 10 2 22222222", rvalid_m, rid_m[7:4], rdata_m[63:32]); end
        tick();
        rvalid_s = 2'b00; rlast_s = 2'b00;
        arvalid_m = 2'b11;
        tick();
        checks++; if (arready_m !== 2'b01 || arid_s[9:5] !== 5'h01) begin errors++; $display("FAIL cont_ptr_wrap: arready %b arid %h exp 01 01", arready_m, arid_s[9:5]); end
        arvalid_m = 2'b00;
    endtask

    task automatic test_parallel;
        do_reset();
        arvalid_m = 2'b11; araddr_m = {32'h0001_0040, 32'h0000_0020};
        arid_m = {4'h7, 4'h3}; arlen_m = {4'd1, 4'd1}; arready_s = 2'b11;
        #1;
        checks++; if (arvalid_s !== 2'b00) begin errors++; $display("FAIL par_bubble: got %b exp 00", arvalid_s); end
        tick();
        checks++; if (arvalid_s !== 2'b11 || araddr_s !== {32'h0001_0040, 32'h0000_0020} || arid_s !== {5'h17, 5'h03})
            begin errors++; $display("FAIL par_ar: arvalid %b addr %h arid %h", arvalid_s, araddr_s, arid_s); end
        tick();
        arvalid_m = 2'b00;
        rvalid_s = 2'b11; rdata_s = {32'hBBBB_0001, 32'hAAAA_0001}; rlast_s = 2'b00;
        rid_s = {5'h17, 5'h03}; rready_m = 2'b11;
        #1;
        checks++; if (rvalid_m !== 2'b11 || rdata_m !== {32'hBBBB_0001, 32'hAAAA_0001} || rid_m !== 8'h73)
            begin errors++; $display("FAIL par_beat1: rvalid %b data %h rid %h", rvalid_m, rdata_m, rid_m); end
        tick();
        rdata_s = {32'hBBBB_0002, 32'hAAAA_0002}; rlast_s = 2'b11; rready_m = 2'b01;
        #1;
        checks++; if (rlast_m !== 2'b11 || rready_s !== 2'b01) begin errors++; $display("FAIL par_beat2: rlast %b rready_s %b exp 11 01", rlast_m, rready_s); end
        tick();
        rvalid_s = 2'b10; rready_m = 2'b10;
        #1;
        checks++; if (rvalid_m !== 2'b10 || rdata_m[63:32] !== 32'hBBBB_0002) begin errors++; $display("FAIL par_m1_stall: rvalid %b data %h exp 10 bbbb0002", rvalid_m, rdata_m[63:32]); end
        tick();
        rvalid_s = 2'b00; rlast_s = 2'b00;
        #1;
        checks++; if (rvalid_m !== 2'b00) begin errors++; $display("FAIL par_done: got %b exp 00", rvalid_m); end
    endtask

    task automatic test_unmapped;
        do_reset();
        arvalid_m = 2'b10; araddr_m[63:32] = 32'hFFFF_0000; arlen_m[7:4] = 4'd2; arid_m[7:4] = 4'h9;
        arready_s = 2'b11;
        tick();
        checks++; if (arready_m !== 2'b10 || arvalid_s !== 2'b00) begin errors++; $display("FAIL unm_ar: arready %b arvalid_s %b exp 10 00", arready_m, arvalid_s); end
        tick();
        arvalid_m = 2'b00; rready_m = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rvalid_m !== 2'b10 || rresp_m[3:2] !== 2'b11 || rdata_m !== 64'h0)
                begin errors++; $display("FAIL unm_beat %0d: rvalid %b resp %b data %h exp 10 11 0", i, rvalid_m, rresp_m[3:2], rdata_m); end
            checks++; if (rlast_m !== ((i == 2) ? 2'b10 : 2'b00) || rid_m[7:4] !== 4'h9 || arvalid_s !== 2'b00)
                begin errors++; $display("FAIL unm_last %0d: rlast %b rid %h arvalid_s %b", i, rlast_m, rid_m[7:4], arvalid_s); end
            tick();
        end
        #1;
        checks++; if (rvalid_m !== 2'b00) begin errors++; $display("FAIL unm_done: got %b exp 00", rvalid_m); end
    endtask

    task automatic test_backpressure;
        int beat;
        do_reset();
        arvalid_m = 2'b01; araddr_m[31:0] = 32'h0000_0100; arlen_m[3:0] = 4'd3; arready_s = 2'b01;
        tick();
        tick();
        beat = 0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            rready_m = (cyc % 2 == 0) ? 2'b01 : 2'b00;
            rvalid_s = 2'b01; rdata_s[31:0] = 32'hC0 + beat; rlast_s[0] = (beat == 3);
            #1;
            checks++; if (rdata_m[31:0] !== 32'hC0 + beat || rvalid_m !== 2'b01)
                begin errors++; $display("FAIL bp_data cyc %0d: data %h rvalid %b exp %h 01", cyc, rdata_m[31:0], rvalid_m, 32'hC0 + beat); end
            checks++; if (rready_s[0] !== rready_m[0] || arready_m !== 2'b00 || arvalid_s !== 2'b00)
                begin errors++; $display("FAIL bp_busy cyc %0d: rready_s %b arready %b arvalid_s %b", cyc, rready_s, arready_m, arvalid_s); end
            tick();
            if (cyc % 2 == 0) beat++;
        end
        rvalid_s = 2'b00; rlast_s = 2'b00; rready_m = 2'b00;
        #1;
        checks++; if (arvalid_s !== 2'b00) begin errors++; $display("FAIL bp_idle: arvalid_s %b exp 00", arvalid_s); end
        tick();
        checks++; if (arvalid_s !== 2'b01 || arready_m !== 2'b01) begin errors++; $display("FAIL bp_regrant: arvalid_s %b arready %b exp 01 01", arvalid_s, arready_m); end
        arvalid_m = 2'b00;
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        arvalid_m = 2'b01; araddr_m[31:0] = 32'h0000_0030; arlen_m[3:0] = 4'd3; arready_s = 2'b01;
        tick();
        tick();
        arvalid_m = 2'b00;
        rvalid_s = 2'b01; rdata_s[31:0] = 32'h1; rready_m = 2'b01;
        #1;
        checks++; if (rvalid_m !== 2'b01) begin errors++; $display("FAIL mid_beat1: rvalid %b exp 01", rvalid_m); end
        tick();
        rdata_s[31:0] = 32'h2;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        #1;
        checks++; if (rvalid_m !== 2'b00 || rready_s !== 2'b00 || arvalid_s !== 2'b00 || arready_m !== 2'b00 || rdata_m !== 64'h0)
            begin errors++; $display("FAIL mid_after_reset: rvalid %b rready_s %b arvalid_s %b arready %b data %h", rvalid_m, rready_s, arvalid_s, arready_m, rdata_m); end
        rvalid_s = 2'b00;
        arvalid_m = 2'b01; araddr_m[31:0] = 32'h0000_0040; arlen_m[3:0] = 4'd0;
        tick();
        checks++; if (arvalid_s !== 2'b01 || araddr_s[31:0] !== 32'h40 || arlen_s[3:0] !== 4'd0)
            begin errors++; $display("FAIL mid_fresh_ar: arvalid %b addr %h len %h", arvalid_s, araddr_s[31:0], arlen_s[3:0]); end
        tick();
        arvalid_m = 2'b00;
        rvalid_s = 2'b01; rlast_s = 2'b01; rdata_s[31:0] = 32'h55;
        #1;
        checks++; if (rvalid_m !== 2'b01 || rlast_m !== 2'b01 || rdata_m[31:0] !== 32'h55)
            begin errors++; $display("FAIL mid_fresh_r: rvalid %b rlast %b data %h exp 01 01 55", rvalid_m, rlast_m, rdata_m[31:0]); end
        tick();
        rvalid_s = 2'b00; rlast_s = 2'b00;
        #1;
        checks++; if (rvalid_m !== 2'b00) begin errors++; $display("FAIL mid_done: rvalid %b exp 00", rvalid_m); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        areset = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_parallel();
        test_unmapped();
        test_backpressure();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_read_xbar.md
# axi_read_xbar

Parametrised AXI read-channel crossbar connecting NM masters to NS slaves, plus an internal decode-error responder for unmapped addresses. It generalises the fixed 2-master/2-slave read path of the AXI top to any master and slave count. Arbitration is round-robin per slave, address maps are set by parameters, and slave IDs carry the master index. It sits between the CPU/DMA masters and the memory/peripheral slaves inside the AXI top.

## Interface
- NM, 2: number of masters (≥1)
- NS, 2: number of mapped slaves (≥1)
- IDM_BITS, 4: master-side ID width
- MI_BITS, $clog2(NM) (min 1): master-index width; IDS_BITS = IDM_BITS+MI_BITS
- ADDR_BITS, 32; DATA_BITS, 32; LEN_BITS, 4
- SLV_BASE, {NS{32'h0}}: packed per-slave base addresses, slave j at [j*ADDR_BITS +: ADDR_BITS]
- SLV_MASK, {NS{32'hFFFF_0000}}: packed per-slave masks; slave j hit when (addr & MASK_j) == BASE_j
- ACLK in 1: clock
- ARESET in 1: synchronous, active-high reset
- ARID_M/ARADDR_M/ARLEN_M/ARSIZE_M/ARBURST_M in NM× field width: packed master AR payloads
- ARVALID_M in NM; ARREADY_M out NM
- RID_M out NM*IDM_BITS; RDATA_M out NM*DATA_BITS; RRESP_M out NM*2; RLAST_M out NM; RVALID_M out NM; RREADY_M in NM
- ARID_S out NS*IDS_BITS; ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S out NS× field width; ARVALID_S out NS; ARREADY_S in NS
- RID_S in NS*IDS_BITS; RDATA_S in NS*DATA_BITS; RRESP_S in NS*2; RLAST_S in NS; RVALID_S in NS; RREADY_S out NS

## Operation
- Decode: each master's ARADDR is matched against all slaves. On multiple hits, the lowest index wins. No hit selects the internal error target E (index NS).
- Master busy flag: set on that master's AR handshake, cleared on its R handshake with RLAST. A busy master's ARVALID is ignored, giving one outstanding read per master, so R paths never conflict at a master.
- Per target t (slaves 0..NS-1 and E) FSM:
  - IDLE: requesters are non-busy masters with ARVALID decoded to t. If any exist, pick the first at or after rr_ptr[t] (wrapping), register grant[t], and go to ADDR.
  - ADDR: ARVALID_S[t] equals ARVALID_M of the granted master. Payload is that master's, with ARID_S = {grant, ARID_M}. ARREADY_M[grant] = ARREADY_S[t]. On handshake go to DATA.
  - DATA: R is routed from t to master grant[t], with RID_M = RID_S[IDM_BITS-1:0] and RREADY_S[t] = RREADY_M[grant]. On an R handshake with RLAST, go to IDLE and set rr_ptr[t] = grant+1 mod NM.
- Target E:
  - ARREADY=1 in ADDR; it latches ARLEN and ARID.
  - In DATA it returns ARLEN+1 beats with RDATA=0, RRESP=2'b11 (DECERR), and RLAST on the final beat.
  - A beat counter decrements per handshake.
- Ungranted masters see ARREADY_M=0 and RVALID_M=0. Idle slaves see ARVALID_S=0 and RREADY_S=0.

## Timing
- Reset: all FSMs go to IDLE, rr_ptr=0, busy=0, E counter=0. All VALID/READY outputs are 0 and all payload outputs are 0 in the cycle after ARESET is sampled high.
- Reset mid-burst aborts the burst. No R beat is forwarded after reset.
- AR latency: ARVALID_M seen in IDLE gives ARVALID_S high on the next cycle, a 1-cycle grant bubble. The payload path is combinational thereafter.
- R path (RVALID/RDATA/RLAST/RREADY) is fully combinational: zero added latency, full throughput of one beat per cycle.
- E: first R beat is the cycle after the AR handshake, then one beat per cycle while RREADY_M=1.
- Same-cycle requests from several masters to one target are resolved by rr_ptr. Losers hold ARVALID and are served in order.
- RLAST handshake and a new request in the same cycle: the target returns to IDLE, and the new grant is registered on the following cycle.
- The busy flag clears in the same cycle as the RLAST handshake, so the master may be granted in the next IDLE evaluation.
- Wrap: rr_ptr wraps NM-1 → 0. E counter covers ARLEN=2^LEN_BITS-1 (16 beats at default).

## Test plan
- Single read: M0 reads 0x0000_0010 (slave 0), ARLEN=3 → ARID_S0={0,ARID}, 4 beats on M0 with RLAST on beat 4, M1 R outputs stay 0.
- Contention: M0 and M1 assert ARVALID to slave 1 in the same cycle after reset → M0 granted first. After M0's RLAST, M1 is granted, and rr_ptr[1]=0 at the end.
- Parallel: M0→slave 0 and M1→slave 1 in the same cycle → both ARVALID_S high the next cycle, with R streams concurrent and independent.
- Unmapped: M1 reads 0xFFFF_0000 with ARLEN=2 → 3 beats, RRESP=2'b11, RDATA=0, RLAST on beat 3. No ARVALID on any slave.
- Backpressure/busy: RREADY_M0 toggles 1/0 during a 4-beat burst → beats are held stable while stalled. A second ARVALID from M0 is not granted until RLAST is accepted.
- Reset mid-burst: ARESET is high during beat 2 of 4 → all VALID/READY are 0 the next cycle, and a fresh read after reset completes normally.
